// File: rtl/instr_dispatch.sv
// Instruction dispatcher: decodes an accepted opcode against a packed table,
// fires a one-cycle one-hot start to the matching execution unit, then waits
// for that unit's done or a bounded timeout before accepting again.
module instr_dispatch #(
    parameter int unsigned                     OPC_W    = 4,
    parameter int unsigned                     NUM_OPS  = 4,
    parameter logic [NUM_OPS*OPC_W-1:0]        OP_TABLE = 16'h21F7,
    parameter int unsigned                     TIMEOUT  = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               instr_valid,
    input  logic [OPC_W-1:0]   opcode,
    output logic               instr_ready,
    output logic [NUM_OPS-1:0] start,
    input  logic [NUM_OPS-1:0] done,
    output logic               busy,
    output logic               illegal,
    output logic               timeout,
    output logic [NUM_OPS-1:0] active_op
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

    state_e             state_q;
    logic [15:0]        timer_q;
    logic [NUM_OPS-1:0] match_oh;
    logic               match_any;
    logic               accept;

    assign instr_ready = (state_q == StIdle) && enable;
    assign busy        = (state_q != StIdle);
    assign accept      = instr_valid && instr_ready;

    // Table lookup; scanning from the top down lets the lowest matching index win.
    always_comb begin
        match_oh  = '0;
        match_any = 1'b0;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (opcode == OP_TABLE[i*OPC_W +: OPC_W]) begin
                match_oh    = '0;
                match_oh[i] = 1'b1;
                match_any   = 1'b1;
            end
        end
    end

    // Dispatch FSM with registered start/illegal/timeout pulses and active unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            start     <= '0;
            active_op <= '0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            start   <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (match_any) begin
                            active_op <= match_oh;
                            start     <= match_oh;
                            state_q   <= StStart;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                StStart: begin
                    state_q <= StWait;
                    timer_q <= '0;
                end
                StWait: begin
                    // Completion takes priority over a coincident timer expiry.
                    if (|(done & active_op)) begin
                        state_q   <= StIdle;
                        active_op <= '0;
                    end else if (timer_q == TimerLast) begin
                        state_q   <= StIdle;
                        active_op <= '0;
                        timeout   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    active_op <= '0;
                end
            endcase
        end
    end

endmodule
